// File: rtl/syscall_pkg.sv
// ============================================================================
// Module : syscall_pkg
// Brief  : Shared state encoding and default syscall codes for syscall_ctrl.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package syscall_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_PAUSE   = 2'd1,
    ST_RELEASE = 2'd2,
    ST_HALT    = 2'd3
  } state_t;

  localparam logic [31:0] DEF_EXIT_CODE  = 32'd10;
  localparam logic [31:0] DEF_PAUSE_CODE = 32'd50;

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// Module : sync_fifo
// Brief  : Single-clock FIFO with combinational head; push on full is legal
//          only together with a pop.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push_i,
  input  logic [DATA_W-1:0]             data_i,
  input  logic                          pop_i,
  output logic [DATA_W-1:0]             data_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [$clog2(FIFO_DEPTH):0]   count_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic              do_push;
  logic              do_pop;

  assign full_o  = (count_q == CW'(FIFO_DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // When full, the write slot equals the read slot; the head is read before
  // the edge, so overwriting it together with a pop is safe.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/syscall_ctrl.sv
// ============================================================================
// Module : syscall_ctrl
// Brief  : Syscall decode, pause/halt FSM, PC stall and display FIFO control.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module syscall_ctrl
  import syscall_pkg::*;
#(
  parameter int          DATA_W     = 32,
  parameter int          FIFO_DEPTH = 4,
  parameter int          CNT_W      = 32,
  parameter logic [31:0] EXIT_CODE  = DEF_EXIT_CODE,
  parameter logic [31:0] PAUSE_CODE = DEF_PAUSE_CODE
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          sys_valid,
  input  logic [31:0]                   sys_code,
  input  logic [DATA_W-1:0]             sys_arg,
  input  logic                          retire,
  input  logic                          resume,
  output logic                          cpu_stall,
  output logic                          halted,
  output logic [DATA_W-1:0]             dout,
  output logic                          dout_valid,
  input  logic                          dout_ready,
  output logic [DATA_W-1:0]             last_disp,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [CNT_W-1:0]              cycle_cnt,
  output logic [CNT_W-1:0]              instr_cnt
);

  state_t            state_q;
  logic              halted_q;
  logic [DATA_W-1:0] last_disp_q;
  logic [CNT_W-1:0]  cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0]  instr_cnt_q, instr_cnt_d;

  logic is_exit, is_pause, is_disp;
  logic fifo_full, fifo_empty, pop, push;

  assign is_exit  = (sys_code == EXIT_CODE);
  assign is_pause = (sys_code == PAUSE_CODE);
  assign is_disp  = ~is_exit & ~is_pause;

  assign dout_valid = ~fifo_empty;
  assign pop        = dout_valid & dout_ready;
  assign push       = (state_q == ST_RUN) & sys_valid & is_disp & (~fifo_full | pop);

  sync_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .data_i  (sys_arg),
    .pop_i   (pop),
    .data_o  (dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // RELEASE deliberately never stalls so the pause syscall can retire once.
  always_comb begin
    cpu_stall = 1'b0;
    case (state_q)
      ST_RUN:     if (sys_valid) cpu_stall = is_disp ? (fifo_full & ~pop) : 1'b1;
      ST_PAUSE:   cpu_stall = 1'b1;
      ST_RELEASE: cpu_stall = 1'b0;
      ST_HALT:    cpu_stall = 1'b1;
      default:    cpu_stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_RUN;
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (sys_valid && is_exit) begin
            state_q  <= ST_HALT;
            halted_q <= 1'b1;
          end else if (sys_valid && is_pause) begin
            state_q <= ST_PAUSE;
          end
        end
        ST_PAUSE:   if (resume) state_q <= ST_RELEASE;
        ST_RELEASE: state_q <= ST_RUN;
        ST_HALT:    halted_q <= 1'b1;
        default:    state_q <= ST_RUN;
      endcase
    end
  end

  assign cycle_cnt_d = (state_q != ST_HALT) ? cycle_cnt_q + CNT_W'(1) : cycle_cnt_q;
  assign instr_cnt_d = (retire && !cpu_stall) ? instr_cnt_q + CNT_W'(1) : instr_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
      last_disp_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
      instr_cnt_q <= instr_cnt_d;
      if (pop) last_disp_q <= dout;
    end
  end

  assign halted    = halted_q;
  assign last_disp = last_disp_q;
  assign cycle_cnt = cycle_cnt_q;
  assign instr_cnt = instr_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_syscall_ctrl.sv
// ============================================================================
// Module : tb_syscall_ctrl
// Brief  : Self-checking bench for syscall_ctrl with a display scoreboard.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_syscall_ctrl;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 32;

  logic              clk, rst_n;
  logic              sys_valid, retire, resume, dout_ready;
  logic [31:0]       sys_code;
  logic [DATA_W-1:0] sys_arg;
  logic              cpu_stall, halted, dout_valid;
  logic [DATA_W-1:0] dout, last_disp;
  logic [2:0]        fifo_count;
  logic [CNT_W-1:0]  cycle_cnt, instr_cnt;

  int                checks = 0;
  int                errors = 0;
  logic [DATA_W-1:0] sb_q[$];
  logic [CNT_W-1:0]  tb_cyc;
  logic [CNT_W-1:0]  exp_instr;
  logic [CNT_W-1:0]  halt_cyc;
  logic              m_halted;

  syscall_ctrl #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (DEPTH),
    .CNT_W      (CNT_W),
    .EXIT_CODE  (32'd10),
    .PAUSE_CODE (32'd50)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sys_valid  (sys_valid),
    .sys_code   (sys_code),
    .sys_arg    (sys_arg),
    .retire     (retire),
    .resume     (resume),
    .cpu_stall  (cpu_stall),
    .halted     (halted),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .last_disp  (last_disp),
    .fifo_count (fifo_count),
    .cycle_cnt  (cycle_cnt),
    .instr_cnt  (instr_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference cycle counter: every edge out of reset until the exit edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_cyc <= '0;
    else if (!m_halted) tb_cyc <= tb_cyc + CNT_W'(1);
  end

  // Scoreboard: every handshake must match the oldest expected value.
  always @(negedge clk) begin
    if (rst_n && dout_valid && dout_ready) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_pop: dout=%h, scoreboard empty", dout);
      end else begin
        automatic logic [DATA_W-1:0] exp = sb_q.pop_front();
        if (dout !== exp) begin
          errors++;
          $display("FAIL sb_data: dout=%h expected=%h", dout, exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 20 && fifo_count != 3'd0; k++) tick();
    checks++;
    if (fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL %s: fifo_count=%0d expected=0", name, fifo_count);
    end
  endtask

  task automatic push_disp(input logic [DATA_W-1:0] arg, input string name);
    sys_valid = 1'b1; sys_code = 32'd3; sys_arg = arg; retire = 1'b1;
    #1;
    checks++;
    if (cpu_stall !== 1'b0) begin
      errors++;
      $display("FAIL %s: cpu_stall=%b expected=0", name, cpu_stall);
    end
    sb_q.push_back(arg);
    exp_instr = exp_instr + CNT_W'(1);
    tick();
    sys_valid = 1'b0; retire = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sys_valid = 1'b0; retire = 1'b0; resume = 1'b0; dout_ready = 1'b0;
    sys_code = '0; sys_arg = '0; m_halted = 1'b0; exp_instr = '0;
    #1;
    checks += 8;
    if (cpu_stall !== 1'b0)  begin errors++; $display("FAIL rst_stall: got=%b exp=0", cpu_stall); end
    if (halted !== 1'b0)     begin errors++; $display("FAIL rst_halted: got=%b exp=0", halted); end
    if (dout_valid !== 1'b0) begin errors++; $display("FAIL rst_dvalid: got=%b exp=0", dout_valid); end
    if (dout !== '0)         begin errors++; $display("FAIL rst_dout: got=%h exp=0", dout); end
    if (last_disp !== '0)    begin errors++; $display("FAIL rst_last: got=%h exp=0", last_disp); end
    if (fifo_count !== 3'd0) begin errors++; $display("FAIL rst_count: got=%0d exp=0", fifo_count); end
    if (cycle_cnt !== '0)    begin errors++; $display("FAIL rst_cycle: got=%0d exp=0", cycle_cnt); end
    if (instr_cnt !== '0)    begin errors++; $display("FAIL rst_instr: got=%0d exp=0", instr_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_display_basic();
    dout_ready = 1'b1;
    push_disp(32'h1234, "basic_stall");
    #1;
    checks += 3;
    if (dout_valid !== 1'b1)   begin errors++; $display("FAIL basic_dvalid: got=%b exp=1", dout_valid); end
    if (dout !== 32'h1234)     begin errors++; $display("FAIL basic_dout: got=%h exp=1234", dout); end
    if (fifo_count !== 3'd1)   begin errors++; $display("FAIL basic_count1: got=%0d exp=1", fifo_count); end
    tick();
    checks += 4;
    if (last_disp !== 32'h1234) begin errors++; $display("FAIL basic_last: got=%h exp=1234", last_disp); end
    if (fifo_count !== 3'd0)    begin errors++; $display("FAIL basic_count0: got=%0d exp=0", fifo_count); end
    if (instr_cnt !== exp_instr) begin errors++; $display("FAIL basic_instr: got=%0d exp=%0d", instr_cnt, exp_instr); end
    if (cycle_cnt !== tb_cyc)   begin errors++; $display("FAIL basic_cycle: got=%0d exp=%0d", cycle_cnt, tb_cyc); end
  endtask

  task automatic test_backpressure();
    dout_ready = 1'b0;
    for (int i = 1; i <= 4; i++) push_disp(DATA_W'(i), "bp_push_stall");
    sys_valid = 1'b1; sys_code = 32'd3; sys_arg = 32'd5; retire = 1'b1;
    #1;
    checks++;
    if (cpu_stall !== 1'b1) begin errors++; $display("FAIL bp_full_stall: got=%b exp=1", cpu_stall); end
    tick();
    checks += 2;
    if (cpu_stall !== 1'b1)  begin errors++; $display("FAIL bp_retry_stall: got=%b exp=1", cpu_stall); end
    if (fifo_count !== 3'd4) begin errors++; $display("FAIL bp_count_full: got=%0d exp=4", fifo_count); end
    dout_ready = 1'b1;
    #1;
    checks++;
    if (cpu_stall !== 1'b0) begin errors++; $display("FAIL bp_release_stall: got=%b exp=0", cpu_stall); end
    sb_q.push_back(32'd5);
    exp_instr = exp_instr + CNT_W'(1);
    tick();
    sys_valid = 1'b0; retire = 1'b0;
    checks++;
    if (fifo_count !== 3'd4) begin errors++; $display("FAIL bp_count_swap: got=%0d exp=4", fifo_count); end
    drain("bp_drain");
    checks++;
    if (instr_cnt !== exp_instr) begin errors++; $display("FAIL bp_instr: got=%0d exp=%0d", instr_cnt, exp_instr); end
  endtask

  task automatic test_pause();
    sys_valid = 1'b1; sys_code = 32'd50; sys_arg = 32'hDEAD; retire = 1'b1;
    #1;
    checks++;
    if (cpu_stall !== 1'b1) begin errors++; $display("FAIL pause_enter: got=%b exp=1", cpu_stall); end
    tick();
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (cpu_stall !== 1'b1) begin errors++; $display("FAIL pause_hold[%0d]: got=%b exp=1", k, cpu_stall); end
      tick();
    end
    resume = 1'b1;
    #1;
    checks++;
    if (cpu_stall !== 1'b1) begin errors++; $display("FAIL pause_resume_cycle: got=%b exp=1", cpu_stall); end
    tick();
    resume = 1'b0;
    #1;
    checks++;
    if (cpu_stall !== 1'b0) begin errors++; $display("FAIL pause_release: got=%b exp=0", cpu_stall); end
    exp_instr = exp_instr + CNT_W'(1);
    tick();
    sys_valid = 1'b0; retire = 1'b0;
    #1;
    checks += 3;
    if (cpu_stall !== 1'b0)      begin errors++; $display("FAIL pause_no_repause: got=%b exp=0", cpu_stall); end
    if (instr_cnt !== exp_instr) begin errors++; $display("FAIL pause_instr: got=%0d exp=%0d", instr_cnt, exp_instr); end
    if (fifo_count !== 3'd0)     begin errors++; $display("FAIL pause_count: got=%0d exp=0", fifo_count); end
  endtask

  task automatic test_exit();
    dout_ready = 1'b0;
    push_disp(32'hA1, "exit_push_stall");
    push_disp(32'hA2, "exit_push_stall");
    sys_valid = 1'b1; sys_code = 32'd10; sys_arg = '0;
    #1;
    checks++;
    if (cpu_stall !== 1'b1) begin errors++; $display("FAIL exit_stall: got=%b exp=1", cpu_stall); end
    tick();
    m_halted = 1'b1;
    sys_valid = 1'b0;
    #1;
    halt_cyc = tb_cyc;
    checks += 3;
    if (halted !== 1'b1)      begin errors++; $display("FAIL exit_halted: got=%b exp=1", halted); end
    if (cpu_stall !== 1'b1)   begin errors++; $display("FAIL exit_hold_stall: got=%b exp=1", cpu_stall); end
    if (cycle_cnt !== halt_cyc) begin errors++; $display("FAIL exit_cycle: got=%0d exp=%0d", cycle_cnt, halt_cyc); end
    resume = 1'b1;
    tick();
    resume = 1'b0; retire = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    checks += 5;
    if (halted !== 1'b1)         begin errors++; $display("FAIL exit_resume_halted: got=%b exp=1", halted); end
    if (cpu_stall !== 1'b1)      begin errors++; $display("FAIL exit_resume_stall: got=%b exp=1", cpu_stall); end
    if (cycle_cnt !== halt_cyc)  begin errors++; $display("FAIL exit_cycle_frozen: got=%0d exp=%0d", cycle_cnt, halt_cyc); end
    if (instr_cnt !== exp_instr) begin errors++; $display("FAIL exit_instr: got=%0d exp=%0d", instr_cnt, exp_instr); end
    if (fifo_count !== 3'd2)     begin errors++; $display("FAIL exit_count: got=%0d exp=2", fifo_count); end
    retire = 1'b0;
    dout_ready = 1'b1;
    drain("exit_drain");
    checks += 2;
    if (halted !== 1'b1)    begin errors++; $display("FAIL exit_after_drain_halted: got=%b exp=1", halted); end
    if (last_disp !== 32'hA2) begin errors++; $display("FAIL exit_last: got=%h exp=a2", last_disp); end
  endtask

  task automatic test_async_reset();
    dout_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b0; m_halted = 1'b0; exp_instr = '0; sb_q.delete();
    #2;
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) push_disp(32'hB1 + DATA_W'(i), "ar_push_stall");
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
    sys_valid = 1'b1; sys_code = 32'd50; retire = 1'b1;
    #1;
    checks++;
    if (cpu_stall !== 1'b1) begin errors++; $display("FAIL ar_pause_stall: got=%b exp=1", cpu_stall); end
    tick();
    tick();
    #2;
    rst_n = 1'b0; sys_valid = 1'b0; retire = 1'b0;
    m_halted = 1'b0; exp_instr = '0; sb_q.delete();
    #1;
    checks += 8;
    if (cpu_stall !== 1'b0)  begin errors++; $display("FAIL ar_stall: got=%b exp=0", cpu_stall); end
    if (halted !== 1'b0)     begin errors++; $display("FAIL ar_halted: got=%b exp=0", halted); end
    if (dout_valid !== 1'b0) begin errors++; $display("FAIL ar_dvalid: got=%b exp=0", dout_valid); end
    if (dout !== '0)         begin errors++; $display("FAIL ar_dout: got=%h exp=0", dout); end
    if (last_disp !== '0)    begin errors++; $display("FAIL ar_last: got=%h exp=0", last_disp); end
    if (fifo_count !== 3'd0) begin errors++; $display("FAIL ar_count: got=%0d exp=0", fifo_count); end
    if (cycle_cnt !== '0)    begin errors++; $display("FAIL ar_cycle: got=%0d exp=0", cycle_cnt); end
    if (instr_cnt !== '0)    begin errors++; $display("FAIL ar_instr: got=%0d exp=0", instr_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    dout_ready = 1'b1;
    push_disp(32'hC0DE, "ar_post_stall");
    #1;
    checks++;
    if (dout !== 32'hC0DE) begin errors++; $display("FAIL ar_post_dout: got=%h exp=c0de", dout); end
    tick();
    checks += 2;
    if (last_disp !== 32'hC0DE)  begin errors++; $display("FAIL ar_post_last: got=%h exp=c0de", last_disp); end
    if (instr_cnt !== exp_instr) begin errors++; $display("FAIL ar_post_instr: got=%0d exp=%0d", instr_cnt, exp_instr); end
  endtask

  task automatic test_back_to_back_full();
    dout_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_disp(32'h10 + DATA_W'(i), "bb_fill_stall");
    #1;
    checks++;
    if (fifo_count !== 3'd4) begin errors++; $display("FAIL bb_full: got=%0d exp=4", fifo_count); end
    dout_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      push_disp(32'h14 + DATA_W'(i), "bb_swap_stall");
      checks++;
      if (fifo_count !== 3'd4) begin errors++; $display("FAIL bb_swap_count: got=%0d exp=4", fifo_count); end
    end
    drain("bb_drain");
    checks += 2;
    if (sb_q.size() != 0)   begin errors++; $display("FAIL bb_sb_left: got=%0d exp=0", sb_q.size()); end
    if (last_disp !== 32'h15) begin errors++; $display("FAIL bb_last: got=%h exp=15", last_disp); end
  endtask

  initial begin
    test_reset();
    test_display_basic();
    test_backpressure();
    test_pause();
    test_exit();
    test_async_reset();
    test_back_to_back_full();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
